// File: rtl/officer_request_conditioner_if.sv
// rtl/officer_request_conditioner_if.sv - request handshake bundle between conditioner and ticket FSM
interface officer_request_conditioner_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_officer;
    logic [3:0] officer_button;

    modport master (
        output req_valid,
        output req_officer,
        output officer_button,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_officer,
        input  officer_button,
        output req_ready
    );
endinterface

// File: rtl/officer_request_conditioner.sv
// rtl/officer_request_conditioner.sv - sync, debounce, queue and round-robin present officer buttons
module officer_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    officer_button_raw,
    officer_request_conditioner_if.master req,
    output logic [3:0]                    pending,
    output logic                          overrun
);
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [3:0] sync1, sync2;
    logic [3:0] stable, stable_q;
    logic [7:0] cnt [4];
    logic [3:0] press;
    logic [1:0] last_grant;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       load;
    logic [3:0] load_mask;
    logic       req_valid_q;
    logic [1:0] req_officer_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= officer_button_raw;
            sync2 <= sync1;
        end
    end

    // Flip the debounced level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    assign press = stable & ~stable_q;

    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_grant + 2'(i);
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign load      = (!req_valid_q || req.req_ready) && (pending != 4'b0000);
    assign load_mask = load ? (4'b0001 << winner) : 4'b0000;

    // A press landing on the same edge as its own load keeps the bit set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q      <= '0;
            pending       <= '0;
            overrun       <= 1'b0;
            last_grant    <= 2'd3;
            req_valid_q   <= 1'b0;
            req_officer_q <= '0;
        end else begin
            stable_q <= stable;
            pending  <= (pending & ~load_mask) | press;
            overrun  <= |(press & pending);
            if (load) begin
                req_valid_q   <= 1'b1;
                req_officer_q <= winner;
                last_grant    <= winner;
            end else if (req_valid_q && req.req_ready) begin
                req_valid_q <= 1'b0;
            end
        end
    end

    assign req.req_valid      = req_valid_q;
    assign req.req_officer    = req_officer_q;
    assign req.officer_button = req_valid_q ? (4'b0001 << req_officer_q) : 4'b0000;
endmodule

// File: tb/tb_officer_request_conditioner.sv
// tb/tb_officer_request_conditioner.sv - directed vector bench for officer_request_conditioner
module tb_officer_request_conditioner;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] raw = 4'b0000;
    logic [3:0] pending;
    logic       overrun;
    int         checks = 0;
    int         errors = 0;

    officer_request_conditioner_if bus ();

    officer_request_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .officer_button_raw (raw),
        .req                (bus),
        .pending            (pending),
        .overrun            (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         rst;
        logic [3:0] raw;
        logic       rdy;
        int         n;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] pack(logic v, logic [1:0] o, logic [3:0] b, logic [3:0] p, logic ov);
        return {v, o, b, p, ov};
    endfunction

    task automatic add(string name, bit rst, logic [3:0] r, logic rdy, int n,
                       logic v, logic [1:0] o, logic [3:0] b, logic [3:0] p, logic ov);
        vec_t x;
        x.name = name; x.rst = rst; x.raw = r; x.rdy = rdy; x.n = n;
        x.exp  = pack(v, o, b, p, ov);
        vecs.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        raw = 4'b0000;
        bus.req_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    // Officer field is only meaningful while a request is presented.
    function automatic logic [11:0] actual(logic exp_valid);
        return pack(bus.req_valid, exp_valid ? bus.req_officer : 2'b00,
                    bus.officer_button, pending, overrun);
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got v=%b o=%0d b=%b p=%b ov=%b, expected v=%b o=%0d b=%b p=%b ov=%b",
                     name, act[11], act[10:9], act[8:5], act[4:1], act[0],
                     exp[11], exp[10:9], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    initial begin
        bit seen_valid;
        bus.req_ready = 1'b0;

        // single press, immediate accept
        add("t1_settle",   1, 4'b0100, 1, 6, 0, 0, 4'b0000, 4'b0000, 0);
        add("t1_pending",  0, 4'b0100, 1, 1, 0, 0, 4'b0000, 4'b0100, 0);
        add("t1_valid",    0, 4'b0100, 1, 1, 1, 2, 4'b0100, 4'b0000, 0);
        add("t1_drop",     0, 4'b0100, 1, 1, 0, 0, 4'b0000, 4'b0000, 0);
        add("t1_hold",     0, 4'b0100, 1, 1, 0, 0, 4'b0000, 4'b0000, 0);
        add("t1_release",  0, 4'b0000, 1, 8, 0, 0, 4'b0000, 4'b0000, 0);
        // glitch and bounce rejection, then one clean press
        add("t2_glitch",   0, 4'b0010, 1, 3, 0, 0, 4'b0000, 4'b0000, 0);
        add("t2_quiet",    0, 4'b0000, 1, 8, 0, 0, 4'b0000, 4'b0000, 0);
        add("t2_b1",       0, 4'b0010, 1, 1, 0, 0, 4'b0000, 4'b0000, 0);
        add("t2_b0",       0, 4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0000, 0);
        add("t2_b1b",      0, 4'b0010, 1, 1, 0, 0, 4'b0000, 4'b0000, 0);
        add("t2_b0b",      0, 4'b0000, 1, 6, 0, 0, 4'b0000, 4'b0000, 0);
        add("t2_settle",   0, 4'b0010, 1, 6, 0, 0, 4'b0000, 4'b0000, 0);
        add("t2_pending",  0, 4'b0010, 1, 1, 0, 0, 4'b0000, 4'b0010, 0);
        add("t2_valid",    0, 4'b0010, 1, 1, 1, 1, 4'b0010, 4'b0000, 0);
        add("t2_drop",     0, 4'b0010, 1, 1, 0, 0, 4'b0000, 4'b0000, 0);
        add("t2_release",  0, 4'b0000, 1, 8, 0, 0, 4'b0000, 4'b0000, 0);
        // simultaneous presses of officers 0 and 3
        add("t3_settle",   1, 4'b1001, 1, 6, 0, 0, 4'b0000, 4'b0000, 0);
        add("t3_pending",  0, 4'b1001, 1, 1, 0, 0, 4'b0000, 4'b1001, 0);
        add("t3_grant0",   0, 4'b1001, 1, 1, 1, 0, 4'b0001, 4'b1000, 0);
        add("t3_grant3",   0, 4'b1001, 1, 1, 1, 3, 4'b1000, 4'b0000, 0);
        add("t3_drop",     0, 4'b1001, 1, 1, 0, 0, 4'b0000, 4'b0000, 0);
        add("t3_release",  0, 4'b0000, 1, 8, 0, 0, 4'b0000, 4'b0000, 0);
        // stalled FSM: requeue without overrun, then overrun on third press
        add("t4_settle",   1, 4'b0010, 0, 6, 0, 0, 4'b0000, 4'b0000, 0);
        add("t4_pending",  0, 4'b0010, 0, 1, 0, 0, 4'b0000, 4'b0010, 0);
        add("t4_present",  0, 4'b0010, 0, 1, 1, 1, 4'b0010, 4'b0000, 0);
        add("t4_held",     0, 4'b0000, 0, 8, 1, 1, 4'b0010, 4'b0000, 0);
        add("t4_p2_set",   0, 4'b0010, 0, 6, 1, 1, 4'b0010, 4'b0000, 0);
        add("t4_p2_queue", 0, 4'b0010, 0, 1, 1, 1, 4'b0010, 4'b0010, 0);
        add("t4_p2_keep",  0, 4'b0010, 0, 1, 1, 1, 4'b0010, 4'b0010, 0);
        add("t4_p2_rel",   0, 4'b0000, 0, 8, 1, 1, 4'b0010, 4'b0010, 0);
        add("t4_p3_set",   0, 4'b0010, 0, 6, 1, 1, 4'b0010, 4'b0010, 0);
        add("t4_overrun",  0, 4'b0010, 0, 1, 1, 1, 4'b0010, 4'b0010, 1);
        add("t4_ov_clear", 0, 4'b0010, 0, 1, 1, 1, 4'b0010, 4'b0010, 0);
        add("t4_b2b",      0, 4'b0000, 1, 1, 1, 1, 4'b0010, 4'b0000, 0);
        add("t4_drop",     0, 4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0000, 0);
        add("t4_release",  0, 4'b0000, 1, 8, 0, 0, 4'b0000, 4'b0000, 0);
        // round robin starting with last_grant=1
        add("t5_prime",    1, 4'b0010, 1, 7, 0, 0, 4'b0000, 4'b0010, 0);
        add("t5_prime_g",  0, 4'b0010, 1, 1, 1, 1, 4'b0010, 4'b0000, 0);
        add("t5_prime_r",  0, 4'b0000, 1, 9, 0, 0, 4'b0000, 4'b0000, 0);
        add("t5_settle",   0, 4'b1111, 1, 6, 0, 0, 4'b0000, 4'b0000, 0);
        add("t5_pending",  0, 4'b1111, 1, 1, 0, 0, 4'b0000, 4'b1111, 0);
        add("t5_g2",       0, 4'b1111, 1, 1, 1, 2, 4'b0100, 4'b1011, 0);
        add("t5_g3",       0, 4'b1111, 1, 1, 1, 3, 4'b1000, 4'b0011, 0);
        add("t5_g0",       0, 4'b1111, 1, 1, 1, 0, 4'b0001, 4'b0010, 0);
        add("t5_g1",       0, 4'b1111, 1, 1, 1, 1, 4'b0010, 4'b0000, 0);
        add("t5_drop",     0, 4'b1111, 1, 1, 0, 0, 4'b0000, 4'b0000, 0);
        add("t5_release",  0, 4'b0000, 1, 8, 0, 0, 4'b0000, 4'b0000, 0);

        do_reset();
        check("reset_state", pack(bus.req_valid, bus.req_officer, bus.officer_button, pending, overrun),
              12'h000);

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            raw = vecs[k].raw;
            bus.req_ready = vecs[k].rdy;
            for (int c = 0; c < vecs[k].n; c++) step();
            check(vecs[k].name, actual(vecs[k].exp[11]), vecs[k].exp);
        end

        // async reset while a request is presented and two more are queued
        do_reset();
        bus.req_ready = 1'b0;
        raw = 4'b0001;
        for (int c = 0; c < 8; c++) step();
        raw = 4'b0000;
        for (int c = 0; c < 8; c++) step();
        raw = 4'b0110;
        for (int c = 0; c < 8; c++) step();
        check("t6_before", actual(1'b1), pack(1, 0, 4'b0001, 4'b0110, 0));
        #2;
        reset = 1'b0;
        raw = 4'b0000;
        #1;
        check("t6_async_clear", pack(bus.req_valid, bus.req_officer, bus.officer_button, pending, overrun),
              12'h000);
        step();
        reset = 1'b1;
        bus.req_ready = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.req_valid || pending != 4'b0000) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid) begin
            errors++;
            $display("FAIL t6_after_reset: got activity=1, expected activity=0");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/officer_request_conditioner.md
Name: officer_request_conditioner

Overview:
- Front-end stage sitting directly upstream of the ticket FSM.
- Takes the four raw, bouncy officer push-buttons and synchronises and debounces each one.
- Turns each press into a single queued request and arbitrates simultaneous requests round-robin.
- Presents exactly one officer at a time to the FSM through a valid/ready handshake, plus a clean one-hot officer_button vector for the FSM's existing input.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised samples that must disagree with the debounced state before it flips. Legal range 1..255; 8-bit internal counter per button.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted = 0).
- officer_button_raw  in  4  raw button levels, bit i = officer i, asynchronous to clk.
- req_ready  in  1  FSM can accept the presented request.
- req_valid  out  1  a request is being presented.
- req_officer  out  2  officer index of the presented request.
- officer_button  out  4  one-hot of req_officer while req_valid=1, else 4'b0000.
- pending  out  4  queued, not-yet-presented requests, bit per officer.
- overrun  out  1  one-cycle pulse: press arrived for an officer already in pending.

Behaviour:
- Reset (reset=0), applied asynchronously:
  - All outputs and internal state clear: req_valid=0, req_officer=0, officer_button=0, pending=0, overrun=0.
  - Synchronisers, debounced states and counters clear to 0.
  - Round-robin pointer last_grant=3, so officer 0 has first priority.
  - A reset mid-handshake drops any presented or pending request with no further output.
- Synchroniser: 2-flop per bit, sync1 <= raw, sync2 <= sync1.
- Debounce, per bit:
  - If sync2 == stable, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter would reach DEBOUNCE_CYCLES, stable <= sync2 and the counter clears.
  - Mismatch runs shorter than DEBOUNCE_CYCLES have no effect.
- Press event: stable 0->1 transition detected against a registered copy, giving one event per press. Release (1->0) generates nothing.
- Pending, per bit:
  - A press event sets the bit on the next edge.
  - The bit clears on the edge its request is loaded into the output register.
  - If a press and a load happen for the same bit on the same edge, the press wins and the bit stays set.
  - A press on an already-set bit leaves it set and pulses overrun for one cycle.
- Arbitration/load:
  - Load condition: (req_valid=0 or req_valid & req_ready) and pending != 0.
  - Winner: the first set pending bit scanning cyclically from last_grant+1.
  - On load: req_officer <= winner, req_valid <= 1, last_grant <= winner.
  - With no load and a transfer: req_valid <= 0.
  - Back-to-back transfers are possible, one per cycle.
- Handshake:
  - While req_valid=1 and req_ready=0, req_officer and officer_button hold unchanged.
  - Transfer occurs on an edge where req_valid & req_ready.
  - req_ready is ignored while req_valid=0.
- Latency:
  - Counting the first edge sampling raw=1 as edge 1, the debounced state flips at edge DEBOUNCE_CYCLES+2, pending sets at edge DEBOUNCE_CYCLES+3, and req_valid rises at edge DEBOUNCE_CYCLES+4.
  - With the default, req_valid is high after edge 8 when idle.
- Simultaneous presses: all bits set pending on the same edge and are served in round-robin order.
- officer_button is derived from registered outputs only, with no combinational path from raw inputs.

Test Plan:
1. Reset, raw[2]=1 held 10 cycles, req_ready=1 -> req_valid=1 / req_officer=2 / officer_button=0100 after edge 8 for exactly one cycle; pending returns to 0.
2. raw[1] glitches high for 3 cycles with DEBOUNCE_CYCLES=4, and raw bounces 1-0-1-0 before settling -> no req_valid during glitches; exactly one request after the settle.
3. raw[0] and raw[3] pressed on the same cycle, req_ready=1 -> pending=1001, then grants officer 0 then officer 3 on consecutive cycles.
4. req_ready=0, press officer 1, then press officer 1 again after release -> request held stable, pending[1]=1, no overrun; a third press before the request is accepted -> overrun pulses once.
5. Round-robin fairness: all four held pending repeatedly with last_grant=1 -> grant order 2,3,0,1.
6. Assert reset=0 while req_valid=1 and pending=0110 -> all outputs 0 immediately, before the next clk edge; no request after release.
